mmio_uart_tx: RTL and testbench

// - Memory-mapped UART transmitter on the dmem side of the single-cycle ARM core.
// - Snoops the core's data-memory bus (MemWrite/DataAdr/WriteData) and claims a 2-word address window.
// - Stored bytes go into a FIFO, are serialized 8N1 on tx, and a status word is returned for loads.
// - The top level ORs rd into ReadData when sel is high.

---
 rtl/mmio_uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// Module   : mmio_uart_tx
// Desc     : Memory-mapped UART transmitter that snoops the core's data bus.
//            Stores to TXDATA (BASE+0) queue a byte in a FIFO. Each byte is
//            sent as a start bit, 8 data bits LSB first and a stop bit.
//            Loads from STATUS (BASE+4) return
//            {parity_en, overflow, busy, full, empty}.
// Options  : define UART_TX_PARITY_EN to insert an even-parity bit after the
//            data bits, which gives an 11-bit frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int BW         = $clog2(CLKS_PER_BIT);
  localparam int C_LAST_INT = CLKS_PER_BIT - 1;
  localparam logic [AW:0]   C_DEPTH     = FIFO_DEPTH[AW:0];
  localparam logic [BW-1:0] C_BAUD_LAST = C_LAST_INT[BW-1:0];
`ifdef UART_TX_PARITY_EN
  localparam logic C_PARITY_EN = 1'b1;
`else
  localparam logic C_PARITY_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr, w_count;
  logic          w_empty, w_full;
  logic          w_push_req, w_push, w_pop, w_drop, w_stat_clr;
  logic          r_ovf, r_busy, r_tx;
  logic [2:0]    r_state, w_state_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic          w_baud_done;
  logic [7:0]    r_data;
  logic          w_tx_nxt;
  logic [31:0]   w_status;
  logic          w_unused;

  // Address decode: a[1:0] are ignored, and a[2] selects TXDATA or STATUS.
  assign sel        = (a[31:3] == BASE_ADDR[31:3]);
  assign w_push_req = we & sel & ~a[2];
  assign w_stat_clr = we & sel & a[2] & wd[3];

  // FIFO occupancy comes from the pointer difference. The pointers carry one
  // extra wrap bit, so a full FIFO can be told apart from an empty one.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == C_DEPTH);
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;
  // A store into a full FIFO still fits if the head leaves on the same edge.
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & ~w_push;

  assign w_status = {27'b0, C_PARITY_EN, r_ovf, r_busy, w_full, w_empty};
  assign rd       = (sel && a[2]) ? w_status : 32'h0;
  assign tx       = r_tx;
  assign busy     = r_busy;

  assign w_baud_done = (r_baud == C_BAUD_LAST);

  // These bits are decoded away and intentionally have no effect.
  assign w_unused = &{1'b0, a[1:0], wd[31:8]};

  // FIFO storage write. The array has no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wd[7:0];
  end

  // FIFO pointers advance on an accepted push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Sticky overflow flag. A drop on the same edge as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_stat_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // FSM state register, with the baud and bit counters and the byte being sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      if (w_pop) r_data <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  // Next-state logic. Every state change restarts the baud and bit counters.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = '0;
    w_bit_nxt   = r_bit;
    case (r_state)
      S_IDLE:   if (w_pop) w_state_nxt = S_START;
      S_START:  if (w_baud_done) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_baud_done && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_baud_done) w_state_nxt = S_STOP;
`endif
      S_STOP:   if (w_baud_done) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    if ((w_state_nxt == r_state) && (r_state != S_IDLE) && !w_baud_done) begin
      w_baud_nxt = r_baud + 1'b1;
    end

    if (w_state_nxt != r_state) begin
      w_bit_nxt = '0;
    end else if ((r_state == S_DATA) && w_baud_done) begin
      w_bit_nxt = r_bit + 1'b1;
    end
  end

  // Output logic. The line level is decoded from the next state so that the
  // registered tx changes on the same edge that the FSM does.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = r_data[w_bit_nxt];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = ^r_data;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // Registered line driver and busy flag. Reset forces tx high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= (r_state != S_IDLE) | ~w_empty;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
// Module   : tb_mmio_uart_tx
// Desc     : Self-checking bench for mmio_uart_tx. It checks a table of address
//            decode cases, a few hand-written frame sequences and random bus
//            traffic against a queue-based model of the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          HN    = 16384;
`ifdef UART_TX_PARITY_EN
  localparam int   NB  = 11;
  localparam logic PAR = 1'b1;
`else
  localparam int   NB  = 10;
  localparam logic PAR = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        we    = 1'b0;
  logic [31:0] a     = 32'h0;
  logic [31:0] wd    = 32'h0;
  logic [31:0] rd;
  logic        sel, tx, busy;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd),
    .rd(rd), .sel(sel), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic txh [HN];
  logic bh  [HN];

  // Reference model. It holds the queued bytes, the frame currently on the
  // line as a bit list, and the elapsed clock count inside that frame.
  byte unsigned q[$];
  logic        m_active;
  int          m_t;
  logic [10:0] m_bits;
  logic        m_ovf;
  logic        m_busy;

  typedef struct {
    logic [31:0] addr;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f = {2'b11, d, 1'b0};
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  function automatic logic m_tx();
    if (m_active) return m_bits[m_t / CPB];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] ad);
    if ((ad[31:3] != BASE[31:3]) || !ad[2]) return 32'h0;
    return {27'b0, PAR, m_ovf, m_busy, (q.size() == DEPTH), (q.size() == 0)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_bits   = '1;
    m_ovf    = 1'b0;
    m_busy   = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [31:0] ad, input logic [31:0] d);
    int   cnt;
    logic pop, hit, set;
    cnt = q.size();
    pop = !m_active && (cnt > 0);
    hit = w && (ad[31:3] == BASE[31:3]);
    set = 1'b0;
    m_busy = m_active || (cnt > 0);
    if (m_active) begin
      m_t++;
      if (m_t == NB * CPB) m_active = 1'b0;
    end
    if (pop) begin
      m_bits   = frame_bits(q.pop_front());
      m_active = 1'b1;
      m_t      = 0;
    end
    if (hit && !ad[2]) begin
      if ((cnt < DEPTH) || pop) q.push_back(d[7:0]);
      else set = 1'b1;
    end
    if (hit && ad[2] && d[3]) m_ovf = 1'b0;
    if (set) m_ovf = 1'b1;
  endtask

  // One bus cycle. It is entered at a falling edge and returns at the next one.
  task automatic step(input logic w, input logic [31:0] ad, input logic [31:0] d);
    we = w; a = ad; wd = d;
    #1;
    chk("sel", 32'(sel), 32'(ad[31:3] == BASE[31:3]));
    chk("rd", rd, model_rd(ad));
    @(posedge clk);
    model_edge(w, ad, d);
    @(negedge clk);
    chk("tx", 32'(tx), 32'(m_tx()));
    chk("busy", 32'(busy), 32'(m_busy));
    if (cyc < HN) begin
      txh[cyc] = tx;
      bh[cyc]  = busy;
    end
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || m_active || m_busy) && n < 2000) begin
      step(1'b0, 32'h0, 32'h0);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 32'(n), 32'(0));
  endtask

  // Samples the middle of each bit period of a frame whose start bit begins at history index s.
  task automatic check_frame(input string nm, input int s, input logic [10:0] exp);
    int k;
    for (int b = 0; b < NB; b++) begin
      k = s + b * CPB + CPB / 2;
      chk(nm, 32'(txh[k]), 32'(exp[b]));
    end
  endtask

  initial begin
    logic [31:0] st_idle;
    logic [10:0] e155, e07;
    logic [31:0] ad;
    int          k0, s, r;

    st_idle = {27'b0, PAR, 4'h1};
`ifdef UART_TX_PARITY_EN
    e155 = 11'b10010101010;
    e07  = 11'b11000001110;
`else
    e155 = 11'b01010101010;
    e07  = 11'b01000001110;
`endif
    model_reset();

    vecs[0] = '{BASE + 32'd0, 1'b1, 32'h0};
    vecs[1] = '{BASE + 32'd4, 1'b1, st_idle};
    vecs[2] = '{BASE + 32'd7, 1'b1, st_idle};
    vecs[3] = '{BASE + 32'd3, 1'b1, 32'h0};
    vecs[4] = '{BASE + 32'd5, 1'b1, st_idle};
    vecs[5] = '{BASE + 32'd8, 1'b0, 32'h0};
    vecs[6] = '{32'h0000_1004, 1'b0, 32'h0};
    vecs[7] = '{32'hFFFE_FFFC, 1'b0, 32'h0};

    // Reset held, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Address decode and idle status.
    for (int i = 0; i < 8; i++) begin
      we = 1'b0; a = vecs[i].addr; wd = 32'hFFFF_FFFF;
      #1;
      chk("tbl_sel", 32'(sel), 32'(vecs[i].exp_sel));
      chk("tbl_rd", rd, vecs[i].exp_rd);
      step(1'b0, vecs[i].addr, 32'hFFFF_FFFF);
    end

    // A single frame. wd[31:8] must be ignored.
    k0 = cyc;
    step(1'b1, BASE, 32'h0000_0155);
    repeat (NB * CPB + 4) step(1'b0, 32'h0, 32'h0);
    s = k0 + 1;
    chk("tx_not_early", 32'(txh[k0]), 32'd1);
    check_frame("frame_155", s, e155);
    chk("busy_after_stop", 32'(bh[s + NB * CPB]), 32'd1);
    chk("busy_drop", 32'(bh[s + NB * CPB + 1]), 32'd0);
    drain();

    // Two back-to-back frames separated by exactly one idle clock.
    k0 = cyc;
    step(1'b1, BASE, 32'h0000_00A5);
    step(1'b1, BASE + 32'd2, 32'h0000_003C);
    repeat (2 * NB * CPB + 4) step(1'b0, 32'h0, 32'h0);
    s = k0 + 1;
    chk("b2b_stop", 32'(txh[s + NB * CPB - 1]), 32'd1);
    chk("b2b_gap", 32'(txh[s + NB * CPB]), 32'd1);
    chk("b2b_start2", 32'(txh[s + NB * CPB + 1]), 32'd0);
    drain();

    // Six stores: one popped at once, four queued, and the sixth dropped.
    for (int i = 0; i < 6; i++) step(1'b1, BASE, 32'h11 + 32'(i));
    we = 1'b0; a = BASE + 32'd4;
    #1;
    chk("ovf_status", rd, {27'b0, PAR, 4'hE});
    step(1'b0, BASE + 32'd4, 32'h0);
    step(1'b1, BASE + 32'd4, 32'h8);
    we = 1'b0; a = BASE + 32'd4;
    #1;
    chk("ovf_cleared", rd, {27'b0, PAR, 4'h6});
    step(1'b0, BASE + 32'd4, 32'h0);
    drain();

    // Frame with a known bit pattern (data 1,1,1,0,0,0,0,0).
    k0 = cyc;
    step(1'b1, BASE, 32'h0000_0007);
    repeat (NB * CPB + 4) step(1'b0, 32'h0, 32'h0);
    check_frame("frame_07", k0 + 1, e07);
    drain();

    // Reset asserted during a start bit.
    step(1'b1, BASE, 32'h0000_0081);
    step(1'b1, BASE, 32'h0000_0042);
    step(1'b0, 32'h0, 32'h0);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    we = 1'b0; a = BASE + 32'd4;
    #1;
    chk("rst_status", rd, st_idle);
    step(1'b0, BASE + 32'd4, 32'h0);

    // Random bus traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 22) begin
        step(1'b1, BASE + 32'($urandom_range(0, 3)), $urandom);
      end else if (r < 30) begin
        step(1'b1, BASE + 32'($urandom_range(4, 7)), $urandom);
      end else if (r < 40) begin
        ad = $urandom;
        if (ad[31:3] == BASE[31:3]) ad = ad ^ 32'h8;
        step(1'b1, ad, $urandom);
      end else if (r < 60) begin
        step(1'b0, BASE + 32'($urandom_range(0, 7)), $urandom);
      end else begin
        step(1'b0, $urandom, $urandom);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
